// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and op-class helper for alu_seq
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SLTU  = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_MULHU = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative unsigned shift-add multiply / restoring divide, one bit per cycle
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_hi,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    // r_acc: product high half / partial remainder; r_q: multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic             r_div;
    logic             r_hi;
    logic             r_busy;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_shifted = {r_acc, r_q[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_b};
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        if (r_div) begin
            // A divisor of zero never borrows, giving all-ones quotient and remainder = dividend
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = w_diff[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shifted[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = w_mul_sum[WIDTH:1];
            w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_b    <= '0;
            r_div  <= 1'b0;
            r_hi   <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_acc  <= '0;
            r_q    <= i_a;
            r_b    <= i_b;
            r_div  <= i_div;
            r_hi   <= i_hi;
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Result is taken from the final iteration's next-state so the caller can register it on that edge
    assign o_busy   = r_busy;
    assign o_done   = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_result = r_hi ? w_acc_nxt : w_q_nxt;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked execute-stage ALU; ALU_SEQ_MULDIV_EN enables iterative MUL/MULHU/DIVU/REMU
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             err
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic             w_accept;
    logic             w_mc;
    logic [WIDTH-1:0] w_res;
    logic             w_err;
    logic [SHW-1:0]   w_shamt;

    assign w_shamt  = src2[SHW-1:0];
    assign w_accept = in_valid && in_ready;

`ifdef ALU_SEQ_MULDIV_EN
    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;

    assign w_mc     = is_multicycle(alu_op);
    assign in_ready = (r_state == ST_IDLE) && !w_md_busy;

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_mc),
        .i_div    ((alu_op == ALU_DIVU) || (alu_op == ALU_REMU)),
        .i_hi     ((alu_op == ALU_MULHU) || (alu_op == ALU_REMU)),
        .i_a      (src1),
        .i_b      (src2),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );
`else
    assign w_mc     = 1'b0;
    assign in_ready = (r_state == ST_IDLE);
`endif

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (alu_op)
            ALU_AND:  w_res = src1 & src2;
            ALU_OR:   w_res = src1 | src2;
            ALU_ADD:  w_res = src1 + src2;
            ALU_SUB:  w_res = src1 - src2;
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALU_XOR:  w_res = src1 ^ src2;
            ALU_SLL:  w_res = src1 << w_shamt;
            ALU_SRL:  w_res = src1 >> w_shamt;
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            ALU_SRA:  w_res = $unsigned($signed(src1) >>> w_shamt);
            default:  w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_mc) begin
                        w_next = ST_DONE;
                    end else if ((alu_op == ALU_MUL) || (alu_op == ALU_MULHU)) begin
                        w_next = ST_MUL;
                    end else begin
                        w_next = ST_DIV;
                    end
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_MUL, ST_DIV: begin
                if (w_md_done) begin
                    w_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_mc) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_err    <= w_err;
            end
`ifdef ALU_SEQ_MULDIV_EN
            else if (w_md_done && ((r_state == ST_MUL) || (r_state == ST_DIV))) begin
                r_result <= w_md_result;
                r_zero   <= (w_md_result == '0);
                r_err    <= 1'b0;
            end
`endif
        end
    end

    assign out_valid  = (r_state == ST_DONE);
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign err        = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=32)
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_result;
    logic        zero;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .src1       (src1),
        .src2       (src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure latency and check outputs
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic er,
                         input int lat, input bit release_out);
        int   n;
        logic ir_bad;
        in_valid = 1'b1;
        alu_op   = op;
        src1     = a;
        src2     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_op   = 4'd2;
        src1     = ~a;
        src2     = 32'h5A5A_1234;
        n = 0;
        ir_bad = 1'b0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0) ir_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n + 1, lat);
        check({tag, " result"}, alu_result, res);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, res == 32'd0});
        check({tag, " err"}, {31'd0, err}, {31'd0, er});
        check({tag, " in_ready busy"}, {31'd0, ir_bad | in_ready}, 32'd0);
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, " in_ready after drain"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic bad;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", alu_result, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd1);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        do_op("ADD ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1, 1'b1);
        do_op("ADD wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 1, 1'b1);
        do_op("SUB 5-5", 4'd3, 32'd5, 32'd5, 32'd0, 1'b0, 1, 1'b1);
        do_op("SRA", 4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1, 1'b1);
        do_op("SLT", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b1);
        do_op("SLTU", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1'b1);
        do_op("AND", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 1'b1);
        do_op("OR", 4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1, 1'b1);
        do_op("XOR", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 1'b1);
        do_op("SLL", 4'd6, 32'd1, 32'h3F, 32'h8000_0000, 1'b0, 1, 1'b1);
        do_op("SRL", 4'd7, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1, 1'b1);
        do_op("UNDEF15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1, 1'b1);

`ifdef ALU_SEQ_MULDIV_EN
        do_op("MULHU", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
        do_op("MUL", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b1);
        do_op("DIVU", 4'd12, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b1);
        do_op("REMU", 4'd13, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b1);
        do_op("DIVU by0", 4'd12, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
        do_op("REMU by0", 4'd13, 32'd123, 32'd0, 32'd123, 1'b0, 33, 1'b1);
`else
        do_op("UNDEF10", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1);
        do_op("UNDEF13", 4'd13, 32'd100, 32'd7, 32'd0, 1'b1, 1, 1'b1);
`endif

        // Output stall: result must hold and in_valid pulses must be ignored
        do_op("STALL", 4'd5, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555, 1'b0, 1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            alu_op   = 4'd2;
            src1     = 32'd1;
            src2     = 32'd1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || alu_result !== 32'hAAAA_5555 || zero !== 1'b0 ||
                err !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        check("stall hold", {31'd0, bad}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall drained out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("stall no hidden accept", {31'd0, out_valid}, 32'd0);

`ifdef ALU_SEQ_MULDIV_EN
        in_valid = 1'b1;
        alu_op   = 4'd12;
        src1     = 32'd100;
        src2     = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`else
        do_op("PRE-RST", 4'd1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1, 1'b0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midop rst out_valid", {31'd0, out_valid}, 32'd0);
        check("midop rst in_ready", {31'd0, in_ready}, 32'd1);
        check("midop rst result", alu_result, 32'd0);
        check("midop rst zero", {31'd0, zero}, 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("midop rst no output", {31'd0, bad}, 32'd0);

        do_op("post-rst ADD", 4'd2, 32'd40, 32'd2, 32'd42, 1'b0, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational execute-stage ALU.
- Single-cycle logic/arith/shift ops complete with registered 1-cycle latency.
- Iterative unsigned multiply/divide take WIDTH cycles.
- Sits between decode/issue and writeback; the pipeline stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand/result width; power of two, >=8.
- SHW, $clog2(WIDTH), shift-amount bits taken from src2[SHW-1:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- alu_op  in  4  operation code
- src1  in  WIDTH  operand A
- src2  in  WIDTH  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- alu_result  out  WIDTH  result
- zero  out  1  alu_result==0
- err  out  1  unsupported opcode flag, qualified by out_valid

Behaviour:
- Reset on clk edge with rst=1:
  - state=IDLE.
  - out_valid=0, alu_result=0, zero=1, err=0, in_ready=1.
  - Reset mid-operation aborts the operation with no output.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 XOR, 6 SLL, 7 SRL.
  - 8 SLTU, 9 SRA, 10 MUL (low WIDTH), 11 MULHU (high WIDTH), 12 DIVU, 13 REMU.
  - 14-15 undefined.
- Shifts use src2[SHW-1:0] only. SLT/SLTU give result 1 or 0, zero-extended. Add/sub wrap modulo 2^WIDTH.
- Handshake:
  - Transfer occurs when in_valid && in_ready at a clk edge.
  - in_ready=1 only in IDLE.
  - Operands and op are captured at acceptance; later src changes are ignored.
- States and transitions:
  - IDLE: accept a simple or undefined op -> DONE. Accept MUL/MULHU -> MUL. Accept DIVU/REMU -> DIV.
  - MUL: shift-add, one bit per cycle, count WIDTH cycles -> DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles -> DONE.
  - DONE: out_valid=1 and alu_result/zero/err stable. When out_ready=1 -> IDLE.
- Latency (accept edge to out_valid rising):
  - Simple ops: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
  - Minimum issue interval: 2 cycles (accept in IDLE, drain in DONE with out_ready=1).
- Boundary cases:
  - Divide by zero: DIVU -> all ones; REMU -> src1; err=0.
  - Undefined opcode: result 0, zero=1, err=1, latency 1.
  - Output stall: out_ready held low keeps DONE indefinitely with outputs unchanged. in_valid is ignored meanwhile (in_ready=0).
- zero and err are registered together with alu_result. They never change while out_valid=1.

Optional Feature:
- Macro ALU_SEQ_MULDIV_EN.
- Defined: MUL/MULHU/DIVU/REMU are implemented as above, with the multi-cycle states and datapath.
- Undefined:
  - MUL/DIV states and datapath are removed.
  - Opcodes 10-13 behave as undefined: result 0, err=1, latency 1.
  - in_ready then deasserts for one cycle per op (DONE only).

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_AND..ALU_REMU;
  - state encoding (IDLE, MUL, DIV, DONE);
  - helper function is_multicycle(op).
- One natural sub-module, alu_muldiv_iter:
  - start/busy/done iterative unsigned mul/div engine;
  - instantiated only under ALU_SEQ_MULDIV_EN.
- alu_seq keeps the handshake FSM and the single-cycle datapath.

Test Plan:
- Reset, then ADD src1=0x7FFFFFFF src2=1 -> out_valid 1 cycle later, result 0x80000000, zero=0; SUB 5-5 -> result 0, zero=1.
- SRA src1=0x80000000 src2=0x24 (shamt 4) -> 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles, in_ready=0 throughout; MUL same operands -> 0x00000001.
- DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF, REMU 123/0 -> 123, err=0.
- Hold out_ready=0 for 10 cycles after a result -> result stable, in_valid pulses ignored; assert rst mid-DIV -> out_valid stays 0, in_ready=1 next cycle.
- Opcode 15, and (macro undefined) opcode 10 -> result 0, zero=1, err=1, latency 1.
